// File: rtl/t1_clkrst_pkg.sv
// Shared types and sizing helpers for the emulation clock/reset controller.
// Imported by clock_reset_ctrl.
package t1_clkrst_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        QUIT    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        QC_NONE     = 2'd0,
        QC_WATCHDOG = 2'd1,
        QC_EXTERNAL = 2'd2
    } quit_cause_e;

    // One counter serves both the stretch and the stagger phases, so it must hold the larger limit.
    function automatic int seq_cnt_width(input int stretch, input int stagger);
        int m;
        m = (stretch > stagger) ? stretch : stagger;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_tick_div.sv
// Programmable tick divider: pulses while enabled whenever the counter has reached div_ratio.
// The >= compare lets a live lowering of div_ratio wrap immediately instead of overrunning.
module clk_tick_div #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] div_ratio,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic                 wrap;

    always_comb begin
        wrap  = (cnt_q >= div_ratio);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && wrap;

endmodule

// File: rtl/clock_reset_ctrl.sv
// Stretched, staggered multi-domain reset release with cycle counter, watchdog,
// divided tick and a sticky quit request for the cosim harness.
module clock_reset_ctrl
    import t1_clkrst_pkg::*;
#(
    parameter int NUM_DOMAINS    = 4,
    parameter int STRETCH_CYCLES = 5,
    parameter int STAGGER_CYCLES = 2,
    parameter int CNT_WIDTH      = 64,
    parameter int WD_WIDTH       = 32,
    parameter int DIV_WIDTH      = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   soft_reset_req,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   all_released,
    output logic [CNT_WIDTH-1:0]   cycle_count,
    input  logic [WD_WIDTH-1:0]    watchdog_timeout,
    input  logic                   watchdog_kick,
    input  logic                   ext_quit,
    output logic                   quit_req,
    output logic [1:0]             quit_cause,
    input  logic [DIV_WIDTH-1:0]   div_ratio,
    output logic                   tick
);

    localparam int SEQ_W = seq_cnt_width(STRETCH_CYCLES, STAGGER_CYCLES);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [SEQ_W-1:0] STRETCH_END = SEQ_W'(STRETCH_CYCLES);
    localparam logic [SEQ_W-1:0] STAGGER_END = SEQ_W'(STAGGER_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DOMAINS - 1);

    state_e                 state_q, state_d;
    logic [SEQ_W-1:0]       seq_q, seq_d, seq_inc;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic [CNT_WIDTH-1:0]   cyc_q, cyc_d;
    logic [WD_WIDTH-1:0]    wd_q, wd_d;
    logic [WD_WIDTH:0]      wd_inc;
    logic                   wd_expire;
    quit_cause_e            cause_q, cause_d;
    logic                   div_en;
    logic                   div_clr;

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        idx_d     = idx_q;
        dom_d     = dom_q;
        cyc_d     = cyc_q;
        wd_d      = wd_q;
        cause_d   = cause_q;
        div_clr   = 1'b0;
        seq_inc   = seq_q + 1'b1;
        wd_inc    = {1'b0, wd_q} + 1'b1;
        // A kick in the expiry cycle beats the timeout.
        wd_expire = (watchdog_timeout != '0) && !watchdog_kick &&
                    (wd_inc >= {1'b0, watchdog_timeout});

        unique case (state_q)
            ASSERT: begin
                dom_d = '1;
                seq_d = seq_inc;
                if (seq_inc == STRETCH_END) begin
                    dom_d[0] = 1'b0;
                    seq_d    = '0;
                    if (NUM_DOMAINS == 1) begin
                        state_d = RUN;
                        cyc_d   = '0;
                        wd_d    = '0;
                        div_clr = 1'b1;
                    end else begin
                        state_d = RELEASE;
                        idx_d   = IDX_W'(1);
                    end
                end
            end
            RELEASE: begin
                if (soft_reset_req) begin
                    state_d = ASSERT;
                    dom_d   = '1;
                    seq_d   = '0;
                    idx_d   = '0;
                    cyc_d   = '0;
                    wd_d    = '0;
                    div_clr = 1'b1;
                end else begin
                    seq_d = seq_inc;
                    if (seq_inc == STAGGER_END) begin
                        seq_d        = '0;
                        dom_d[idx_q] = 1'b0;
                        idx_d        = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = RUN;
                            cyc_d   = '0;
                            wd_d    = '0;
                            div_clr = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (cyc_q != '1) begin
                    cyc_d = cyc_q + 1'b1;
                end
                wd_d = watchdog_kick ? '0 : wd_inc[WD_WIDTH-1:0];
                if (wd_expire) begin
                    state_d = QUIT;
                    cause_d = QC_WATCHDOG;
                    dom_d   = '1;
                end else if (soft_reset_req) begin
                    state_d = ASSERT;
                    dom_d   = '1;
                    seq_d   = '0;
                    idx_d   = '0;
                    cyc_d   = '0;
                    wd_d    = '0;
                    div_clr = 1'b1;
                end
            end
            QUIT: begin
                dom_d = '1;
            end
            default: begin
                state_d = ASSERT;
                dom_d   = '1;
            end
        endcase

        // External quit outranks everything else; an existing cause is kept once in QUIT.
        if (ext_quit && state_q != QUIT) begin
            state_d = QUIT;
            cause_d = QC_EXTERNAL;
            dom_d   = '1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ASSERT;
            seq_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '1;
            cyc_q   <= '0;
            wd_q    <= '0;
            cause_q <= QC_NONE;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            cyc_q   <= cyc_d;
            wd_q    <= wd_d;
            cause_q <= cause_d;
        end
    end

    assign div_en = (state_q == RUN);

    clk_tick_div #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick_div (
        .clock    (clock),
        .reset    (reset),
        .en       (div_en),
        .clr      (div_clr),
        .div_ratio(div_ratio),
        .tick     (tick)
    );

    assign domain_reset = dom_q;
    assign all_released = (state_q == RUN);
    assign cycle_count  = cyc_q;
    assign quit_req     = (state_q == QUIT);
    assign quit_cause   = cause_q;

endmodule
